// File: rtl/bus_takeover_if.sv
// bus_takeover_if: request/response and board-bus signals for bus_takeover.
// slave is the arbiter side; master is the requester/board side.
`timescale 1ns/1ps
interface bus_takeover_if;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        keep;
   logic        PHI2sync;
   logic        RWsync;
   logic [7:0]  Din;
   logic        ack;
   logic        err;
   logic [7:0]  rdata;
   logic        cpuRdy;
   logic        busOwn;
   logic [15:0] aOut;
   logic [7:0]  dOut;
   logic        dOe;
   logic        rwOut;
   logic        ramCsN;
   logic        busy;

   modport slave (
      input  req, we, addr, wdata, keep, PHI2sync, RWsync, Din,
      output ack, err, rdata, cpuRdy, busOwn, aOut, dOut, dOe, rwOut, ramCsN, busy
   );

   modport master (
      output req, we, addr, wdata, keep, PHI2sync, RWsync, Din,
      input  ack, err, rdata, cpuRdy, busOwn, aOut, dOut, dOe, rwOut, ramCsN, busy
   );
endinterface

// File: rtl/bus_takeover.sv
// bus_takeover: halts the 6502 via RDY at a safe read cycle, takes the shared
// bus, runs one RAM cycle from the FPGA side, then keeps or returns the bus.
`timescale 1ns/1ps
module bus_takeover #(
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter int unsigned ACCESS_CYCLES = 8,
   parameter int unsigned HOLD_CYCLES   = 2,
   parameter int unsigned HALT_LIMIT    = 8
) (
   input logic           CLK25MHZ,
   input logic           rst_n,
   bus_takeover_if.slave bus
);

   localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] AccessLast = 8'(ACCESS_CYCLES - 1);
   localparam logic [7:0] HoldLast   = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] HaltMax    = 8'(HALT_LIMIT);

   typedef enum logic [3:0] {
      StRun, StHaltWait, StIsolate, StSetup, StStrobe,
      StRecover, StDone, StOwned, StRelease, StTimeout
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  edge_cnt_q, edge_cnt_d;
   logic        phi2_q;
   logic        ack_q;     // ack of the previous cycle; blocks an immediate re-accept
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic        rw_q;      // 1 = read
   logic [7:0]  rdata_q;
   logic        ack_int;
   logic        phi2_fall;
   logic        accept;
   logic        load;
   logic        capture;

   assign phi2_fall = phi2_q & ~bus.PHI2sync;
   assign accept    = bus.req & ~ack_q & ((state_q == StRun) || (state_q == StOwned));

   // Next-state logic, per-state cycle timer and halt edge counter.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 8'd1;
      edge_cnt_d = edge_cnt_q;
      load       = 1'b0;
      capture    = 1'b0;
      unique case (state_q)
         StRun: begin
            if (accept) begin
               state_d    = StHaltWait;
               load       = 1'b1;
               edge_cnt_d = '0;
            end
         end
         StHaltWait: begin
            if (phi2_fall) begin
               edge_cnt_d = edge_cnt_q + 8'd1;
               // First edge may have missed RDY setup; write cycles ignore RDY.
               if ((edge_cnt_q != 8'd0) && bus.RWsync) begin
                  state_d = StIsolate;
               end else if (edge_cnt_d == HaltMax) begin
                  state_d = StTimeout;
               end
            end
         end
         StIsolate: if (cnt_q == SettleLast) state_d = StSetup;
         StSetup:   if (cnt_q == SettleLast) state_d = StStrobe;
         StStrobe: begin
            if (cnt_q == AccessLast) begin
               state_d = StRecover;
               capture = rw_q;
            end
         end
         StRecover: if (cnt_q == HoldLast) state_d = StDone;
         StDone:    state_d = bus.keep ? StOwned : StRelease;
         StOwned: begin
            if (accept) begin
               state_d = StSetup;
               load    = 1'b1;
            end else if (!bus.keep) begin
               state_d = StRelease;
            end
         end
         StRelease: if (cnt_q == SettleLast) state_d = StRun;
         StTimeout: state_d = StRun;
         default:   state_d = StRun;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   // State, timers, latched request fields and captured read data.
   always_ff @(posedge CLK25MHZ or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StRun;
         cnt_q      <= '0;
         edge_cnt_q <= '0;
         phi2_q     <= 1'b0;
         ack_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rw_q       <= 1'b1;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         edge_cnt_q <= edge_cnt_d;
         phi2_q     <= bus.PHI2sync;
         ack_q      <= ack_int;
         if (load) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            rw_q    <= ~bus.we;
         end
         if (capture) rdata_q <= bus.Din;
      end
   end

   assign ack_int     = (state_q == StDone) || (state_q == StTimeout);
   assign bus.ack     = ack_int;
   assign bus.err     = (state_q == StTimeout);
   assign bus.rdata   = rdata_q;
   assign bus.cpuRdy  = (state_q == StRun) || (state_q == StTimeout);
   assign bus.busOwn  = state_q inside {StIsolate, StSetup, StStrobe, StRecover, StDone, StOwned};
   assign bus.aOut    = addr_q;
   assign bus.dOut    = wdata_q;
   assign bus.rwOut   = rw_q;
   assign bus.dOe     = ~rw_q & (state_q inside {StSetup, StStrobe, StRecover});
   assign bus.ramCsN  = (state_q != StStrobe);
   assign bus.busy    = !(state_q inside {StRun, StOwned});

endmodule
